cordic_add_subt_unit: RTL and testbench

Responder end of the beg_add_subt / ready_add_subt / ack_add_subt handshake that CORDIC_FSM drives. It latches two W-bit two's-complement operands on a start request and computes X+Y or X−Y over a fixed multi-cycle latency. It presents the registered result with ready_add_subt and holds it until acknowledged. It sits in the CORDIC datapath and feeds the d_ff_Xn / d_ff_Yn / d_ff_Zn registers.

---
 rtl/cordic_add_subt_unit.sv | 181 ++++++++++++++++++
 tb/tb_cordic_add_subt_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_add_subt_unit.sv
// -----------------------------------------------------------------------------
// cordic_add_subt_unit
//
// Responder end of the beg/ready/ack add-subtract handshake used by the CORDIC
// controller. On a start request in IDLE it captures two W-bit two's-complement
// operands and the operation select, spends a fixed number of CALC cycles, then
// presents a registered result (X+Y or X-Y) with ready_add_subt held high until
// the requester acknowledges it.
//
// Handshake: beg_add_subt is sampled only in IDLE, ack_add_subt only in DONE.
// A beg seen in CALC/DONE is dropped (never queued); an ack outside DONE is
// dropped. If beg and ack are both high in DONE, ack wins and beg must still be
// high on a later IDLE edge to start a new operation.
//
// Parameters:
//   W        operand/result width, 8..64
//   LATENCY  number of CALC cycles, 1..15; ready rises LATENCY+1 edges after
//            the edge that samples beg_add_subt
//
// Optional feature (macro ADD_SUBT_SATURATE_EN):
//   defined   -> Data_Result saturates to the most positive/negative value on
//                signed overflow
//   undefined -> Data_Result is the wrapped low W bits
//   overflow_flag is identical in both builds.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   beg_add_subt    in   start request
//   ack_add_subt    in   result-consumed acknowledge
//   add_subt        in   0 = X+Y, 1 = X-Y (captured with operands)
//   Data_X, Data_Y  in   W-bit operands
//   ready_add_subt  out  result valid, held until ack
//   busy            out  high in CALC and DONE
//   Data_Result     out  registered W-bit result
//   overflow_flag   out  signed overflow of the last operation
//   state_o         out  current FSM state (debug observation)
// -----------------------------------------------------------------------------
module cordic_add_subt_unit #(
  parameter int W       = 32,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         add_subt,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  output logic         ready_add_subt,
  output logic         busy,
  output logic [W-1:0] Data_Result,
  output logic         overflow_flag,
  output logic [1:0]   state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter is loaded with LATENCY on capture and the result is written on
  // the CALC edge that finds it at zero: LATENCY counting edges plus the write
  // edge give ready exactly LATENCY+1 edges after the capture edge.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

  logic [1:0]   state_q,  state_d;
  logic [3:0]   cnt_q,    cnt_d;
  logic [W-1:0] x_q,      x_d;
  logic [W-1:0] y_q,      y_d;
  logic         sub_q,    sub_d;
  logic         ready_q,  ready_d;
  logic         busy_q,   busy_d;
  logic [W-1:0] result_q, result_d;
  logic         ovf_q,    ovf_d;

  // Arithmetic on the captured operands, one bit wider than the operands so
  // that negating the most negative Y is exact.
  logic [W:0]   x_ext;
  logic [W:0]   y_ext;
  logic [W:0]   y_op;
  logic [W:0]   sum;
  logic         sum_ovf;
  logic [W-1:0] sum_res;

  always_comb begin
    x_ext   = {x_q[W-1], x_q};
    y_ext   = {y_q[W-1], y_q};
    y_op    = sub_q ? (~y_ext + (W+1)'(1)) : y_ext;
    sum     = x_ext + y_op;
    sum_ovf = sum[W] ^ sum[W-1];
`ifdef ADD_SUBT_SATURATE_EN
    if (sum_ovf) begin
      // Sign of the wide sum tells the true direction of the overflow.
      sum_res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_res = sum[W-1:0];
    end
`else
    sum_res = sum[W-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    sub_d    = sub_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (beg_add_subt) begin
          x_d     = Data_X;
          y_d     = Data_Y;
          sub_d   = add_subt;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == 4'd0) begin
          result_d = sum_res;
          ovf_d    = sum_ovf;
          ready_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // Result and flag are left untouched so they stay readable after ack.
        if (ack_add_subt) begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      x_q      <= '0;
      y_q      <= '0;
      sub_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sub_q    <= sub_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready_add_subt = ready_q;
  assign busy           = busy_q;
  assign Data_Result    = result_q;
  assign overflow_flag  = ovf_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_cordic_add_subt_unit.sv
module tb_cordic_add_subt_unit;

  localparam int W       = 32;
  localparam int LATENCY = 4;
  localparam int EXP_EDGES = LATENCY + 1;

  logic         clk;
  logic         reset;
  logic         beg_add_subt;
  logic         ack_add_subt;
  logic         add_subt;
  logic [W-1:0] Data_X;
  logic [W-1:0] Data_Y;
  logic         ready_add_subt;
  logic         busy;
  logic [W-1:0] Data_Result;
  logic         overflow_flag;
  logic [1:0]   state_dbg;

  int n_vec;
  int n_err;

  // Expected {overflow, result} per captured operation.
  logic [W:0] exp_q[$];

  cordic_add_subt_unit #(.W(W), .LATENCY(LATENCY)) dut (
    .clk            (clk),
    .reset          (reset),
    .beg_add_subt   (beg_add_subt),
    .ack_add_subt   (ack_add_subt),
    .add_subt       (add_subt),
    .Data_X         (Data_X),
    .Data_Y         (Data_Y),
    .ready_add_subt (ready_add_subt),
    .busy           (busy),
    .Data_Result    (Data_Result),
    .overflow_flag  (overflow_flag),
    .state_o        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Exact signed arithmetic in 64 bits, then range-checked against W bits.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic sub);
    longint sx;
    longint sy;
    longint r;
    longint max_p;
    longint min_n;
    logic   o;
    logic [W-1:0] res;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    r     = sub ? (sx - sy) : (sx + sy);
    max_p = (longint'(1) <<< (W-1)) - 1;
    min_n = -(longint'(1) <<< (W-1));
    o     = (r > max_p) || (r < min_n);
    res   = r[W-1:0];
`ifdef ADD_SUBT_SATURATE_EN
    if (r > max_p) res = max_p[W-1:0];
    if (r < min_n) res = min_n[W-1:0];
`endif
    return {o, res};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
  endtask

  // Present operands with beg high for exactly the capture edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    Data_X       = x;
    Data_Y       = y;
    add_subt     = sub;
    beg_add_subt = 1'b1;
    exp_q.push_back(model(x, y, sub));
    tick();
    beg_add_subt = 1'b0;
  endtask

  // Counts edges after the capture edge until ready is seen (bounded).
  task automatic wait_ready(input int start, output int edges);
    edges = start;
    while (!ready_add_subt && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_ack();
    ack_add_subt = 1'b1;
    tick();
    ack_add_subt = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beg_add_subt = 1'($urandom_range(0, 1));
      ack_add_subt = 1'($urandom_range(0, 1));
      add_subt     = 1'($urandom_range(0, 1));
      Data_X       = $urandom;
      Data_Y       = $urandom;
      tick();
    end
    n_vec++;
    if (ready_add_subt !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_add_subt); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if (Data_Result !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0", Data_Result); end
    n_vec++;
    if (overflow_flag !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_flag); end
    drive_idle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if ({ready_add_subt, busy, overflow_flag} !== 3'b000 || Data_Result !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle: got rdy=%b busy=%b ovf=%b res=%h want all 0",
               ready_add_subt, busy, overflow_flag, Data_Result);
    end
  endtask

  task automatic test_add();
    int edges;
    logic [W:0] e;
    start_op(32'h0000_0005, 32'h0000_0003, 1'b0);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b want 1", busy); end
    wait_ready(0, edges);
    n_vec++;
    if (edges !== EXP_EDGES) begin n_err++; $display("FAIL add_latency: got %0d want %0d", edges, EXP_EDGES); end
    e = exp_q.pop_front();
    n_vec++;
    if (Data_Result !== 32'h0000_0008 || Data_Result !== e[W-1:0]) begin
      n_err++; $display("FAIL add_result: got %h want %h", Data_Result, e[W-1:0]);
    end
    n_vec++;
    if (overflow_flag !== 1'b0) begin n_err++; $display("FAIL add_ovf: got %b want 0", overflow_flag); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (ready_add_subt !== 1'b1 || Data_Result !== e[W-1:0]) begin
        n_err++;
        $display("FAIL add_hold: cycle %0d got rdy=%b res=%h want rdy=1 res=%h",
                 i, ready_add_subt, Data_Result, e[W-1:0]);
      end
    end
    do_ack();
    n_vec++;
    if (ready_add_subt !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL add_ack: got rdy=%b busy=%b want 0 0", ready_add_subt, busy);
    end
    n_vec++;
    if (Data_Result !== e[W-1:0]) begin
      n_err++; $display("FAIL add_keep_after_ack: got %h want %h", Data_Result, e[W-1:0]);
    end
  endtask

  task automatic test_sub_isolation();
    int edges;
    logic [W:0] e;
    start_op(32'h0000_0003, 32'h0000_0005, 1'b1);
    // Operands change right after capture; they must not reach the result.
    Data_X   = 32'hFFFF_FFFF;
    Data_Y   = 32'hFFFF_FFFF;
    add_subt = 1'b0;
    tick();
    beg_add_subt = 1'b1;   // stray start request during CALC
    tick();
    beg_add_subt = 1'b0;
    wait_ready(2, edges);
    n_vec++;
    if (edges !== EXP_EDGES) begin n_err++; $display("FAIL sub_latency: got %0d want %0d", edges, EXP_EDGES); end
    e = exp_q.pop_front();
    n_vec++;
    if (Data_Result !== 32'hFFFF_FFFE || Data_Result !== e[W-1:0]) begin
      n_err++; $display("FAIL sub_result: got %h want %h", Data_Result, e[W-1:0]);
    end
    n_vec++;
    if (overflow_flag !== 1'b0) begin n_err++; $display("FAIL sub_ovf: got %b want 0", overflow_flag); end
    do_ack();
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if (ready_add_subt !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL sub_no_queue: got rdy=%b busy=%b want 0 0", ready_add_subt, busy);
    end
  endtask

  task automatic test_overflow();
    int edges;
    logic [W:0] e;
    logic [W-1:0] xs[2];
    logic [W-1:0] ys[2];
    logic         ss[2];
    logic [W-1:0] want[2];
    xs[0] = 32'h7FFF_FFFF; ys[0] = 32'h0000_0001; ss[0] = 1'b0;
    xs[1] = 32'h8000_0000; ys[1] = 32'h0000_0001; ss[1] = 1'b1;
`ifdef ADD_SUBT_SATURATE_EN
    want[0] = 32'h7FFF_FFFF; want[1] = 32'h8000_0000;
`else
    want[0] = 32'h8000_0000; want[1] = 32'h7FFF_FFFF;
`endif
    for (int i = 0; i < 2; i++) begin
      start_op(xs[i], ys[i], ss[i]);
      wait_ready(0, edges);
      e = exp_q.pop_front();
      n_vec++;
      if (Data_Result !== want[i] || Data_Result !== e[W-1:0]) begin
        n_err++; $display("FAIL ovf_result_%0d: got %h want %h", i, Data_Result, want[i]);
      end
      n_vec++;
      if (overflow_flag !== 1'b1) begin
        n_err++; $display("FAIL ovf_flag_%0d: got %b want 1", i, overflow_flag);
      end
      do_ack();
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [W:0] e1;
    logic [W:0] e2;
    start_op(32'd100, 32'd58, 1'b1);
    wait_ready(0, edges);
    e1 = exp_q.pop_front();
    // beg and ack together in DONE: decoy operands that must not be captured.
    Data_X       = 32'h1111_1111;
    Data_Y       = 32'h2222_2222;
    add_subt     = 1'b0;
    beg_add_subt = 1'b1;
    ack_add_subt = 1'b1;
    tick();
    ack_add_subt = 1'b0;
    n_vec++;
    if (ready_add_subt !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_ack_wins: got rdy=%b busy=%b want 0 0", ready_add_subt, busy);
    end
    n_vec++;
    if (Data_Result !== e1[W-1:0]) begin
      n_err++; $display("FAIL b2b_keep: got %h want %h", Data_Result, e1[W-1:0]);
    end
    // beg still high: this edge captures the real operands.
    Data_X   = 32'h0000_1234;
    Data_Y   = 32'hFFFF_FF00;
    add_subt = 1'b0;
    exp_q.push_back(model(Data_X, Data_Y, add_subt));
    tick();
    beg_add_subt = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_capture: got busy=%b want 1", busy); end
    wait_ready(0, edges);
    n_vec++;
    if (edges !== EXP_EDGES) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", edges, EXP_EDGES); end
    e2 = exp_q.pop_front();
    n_vec++;
    if ({overflow_flag, Data_Result} !== e2) begin
      n_err++; $display("FAIL b2b_result: got %b/%h want %b/%h", overflow_flag, Data_Result, e2[W], e2[W-1:0]);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_op();
    int edges;
    logic [W:0] e;
    logic seen;
    start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
    void'(exp_q.pop_front());  // aborted, never delivered
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({ready_add_subt, busy, overflow_flag} !== 3'b000 || Data_Result !== '0) begin
      n_err++;
      $display("FAIL midop_reset: got rdy=%b busy=%b ovf=%b res=%h want all 0",
               ready_add_subt, busy, overflow_flag, Data_Result);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ready_add_subt) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL midop_no_ready: got %b want 0", seen); end
    reset = 1'b1;
    tick();
    start_op(32'd10, 32'd20, 1'b0);
    wait_ready(0, edges);
    n_vec++;
    if (edges !== EXP_EDGES) begin n_err++; $display("FAIL midop_latency: got %0d want %0d", edges, EXP_EDGES); end
    e = exp_q.pop_front();
    n_vec++;
    if (Data_Result !== 32'd30 || Data_Result !== e[W-1:0]) begin
      n_err++; $display("FAIL midop_result: got %h want %h", Data_Result, e[W-1:0]);
    end
    do_ack();
  endtask

  task automatic test_random();
    int edges;
    logic [W:0] e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       x = 32'h7FFF_FFFF;
        1:       x = 32'h8000_0000;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       y = 32'h8000_0000;
        1:       y = 32'($urandom_range(0, 3));
        default: y = $urandom;
      endcase
      start_op(x, y, 1'($urandom_range(0, 1)));
      wait_ready(0, edges);
      n_vec++;
      if (edges !== EXP_EDGES) begin n_err++; $display("FAIL rnd_latency_%0d: got %0d want %0d", n, edges, EXP_EDGES); end
      e = exp_q.pop_front();
      n_vec++;
      if ({overflow_flag, Data_Result} !== e) begin
        n_err++;
        $display("FAIL rnd_result_%0d: x=%h y=%h sub=%b got %b/%h want %b/%h",
                 n, x, y, add_subt, overflow_flag, Data_Result, e[W], e[W-1:0]);
      end
      for (int d = 0; d < $urandom_range(0, 3); d++) tick();
      do_ack();
      for (int d = 0; d < $urandom_range(0, 2); d++) tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    drive_idle();
    add_subt = 1'b0;
    Data_X   = '0;
    Data_Y   = '0;
    test_reset();
    test_add();
    test_sub_isolation();
    test_overflow();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
